add_sub: RTL and testbench

ADD_SUB -- requirements
Module: add_sub

---
 rtl/add_sub_pkg.sv | 10 +
 rtl/add_sub_full_adder.sv | 14 +
 rtl/add_sub.sv | 66 ++++++
 tb/tb_add_sub.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/add_sub_pkg.sv
// Shared constants for the add_sub block: mode encoding for c0 and the
// default operand width.
package add_sub_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  localparam int DEFAULT_WIDTH = 4;

endpackage : add_sub_pkg

// File: rtl/add_sub_full_adder.sv
// One-bit full adder cell; add_sub chains WIDTH of these into a
// ripple-carry adder.
module full_adder (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic sum,
  output logic co
);

  assign sum = x ^ y ^ ci;
  assign co  = (x & y) | (ci & (x ^ y));

endmodule : full_adder

// File: rtl/add_sub.sv
// Registered two's-complement adder/subtractor. Subtraction is a + ~b + 1,
// so c0 both inverts b and feeds the carry-in of bit 0.
module add_sub
  import add_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c0,
  input  logic             in_valid,
  output logic [WIDTH-1:0] s,
  output logic             ovf,
  output logic             cout,
  output logic             out_valid
);

  logic             sub_mode;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum_comb;
  logic [WIDTH:0]   carry;
  logic             ovf_comb;

  assign sub_mode = (c0 == MODE_SUB);
  assign b_eff    = b ^ {WIDTH{sub_mode}};
  assign carry[0] = sub_mode;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
    full_adder u_fa (
      .x   (a[i]),
      .y   (b_eff[i]),
      .ci  (carry[i]),
      .sum (sum_comb[i]),
      .co  (carry[i+1])
    );
  end

  // Signed overflow: the carry into the sign bit disagrees with the carry out.
  assign ovf_comb = carry[WIDTH-1] ^ carry[WIDTH];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
    end
  end

  // Result registers load only on a valid cycle and otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s    <= '0;
      ovf  <= 1'b0;
      cout <= 1'b0;
    end else if (in_valid) begin
      s    <= sum_comb;
      ovf  <= ovf_comb;
      cout <= carry[WIDTH];
    end
  end

endmodule : add_sub

// File: tb/tb_add_sub.sv
// Self-checking bench for add_sub (WIDTH=4): directed vectors, valid/hold,
// mid-stream reset and randomized traffic against an integer reference model.
module tb_add_sub;
  import add_sub_pkg::*;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c0;
  logic         in_valid;
  logic [W-1:0] s;
  logic         ovf;
  logic         cout;
  logic         out_valid;

  int checks = 0;
  int errors = 0;

  // Expected registered outputs, maintained by the bench.
  logic [W-1:0] exp_s;
  logic         exp_ovf;
  logic         exp_cout;
  logic         exp_v;

  add_sub #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .c0        (c0),
    .in_valid  (in_valid),
    .s         (s),
    .ovf       (ovf),
    .cout      (cout),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Reference: true signed/unsigned arithmetic, then derive the flags.
  task automatic model(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                       input logic tc, output logic [W-1:0] rs,
                       output logic rovf, output logic rcout);
    int sa, sb, r;
    int ua, ub;
    sa = $signed(ta);
    sb = $signed(tb_v);
    ua = int'(ta);
    ub = int'(tb_v);
    r  = (tc == MODE_SUB) ? sa - sb : sa + sb;
    rs    = r[W-1:0];
    rovf  = (r > (2**(W-1)) - 1) || (r < -(2**(W-1)));
    rcout = (tc == MODE_SUB) ? (ua >= ub) : (ua + ub >= 2**W);
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".s"},         32'(s),         32'(exp_s));
    check({tag, ".ovf"},       32'(ovf),       32'(exp_ovf));
    check({tag, ".cout"},      32'(cout),      32'(exp_cout));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(exp_v));
  endtask

  // Apply one cycle of inputs, let the edge pass, update expectations, check.
  task automatic cycle(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                       input logic tc, input logic tv, input string tag);
    logic [W-1:0] ms;
    logic         mo, mc;
    a = ta; b = tb_v; c0 = tc; in_valid = tv;
    @(posedge clk);
    #1;
    if (tv) begin
      model(ta, tb_v, tc, ms, mo, mc);
      exp_s = ms; exp_ovf = mo; exp_cout = mc;
    end
    exp_v = tv;
    check_outputs(tag);
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c0;
    logic [W-1:0] s;
    logic         ovf;
    logic         cout;
  } vec_t;

  vec_t vecs[9] = '{
    '{4'b0011, 4'b0001, 1'b0, 4'b0100, 1'b0, 1'b0},
    '{4'b0010, 4'b0100, 1'b0, 4'b0110, 1'b0, 1'b0},
    '{4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b1, 1'b0},
    '{4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1, 1'b1},
    '{4'b1111, 4'b1000, 1'b1, 4'b0111, 1'b0, 1'b1},
    '{4'b1000, 4'b1000, 1'b1, 4'b0000, 1'b0, 1'b1},
    '{4'b1101, 4'b1100, 1'b1, 4'b0001, 1'b0, 1'b1},
    '{4'b1000, 4'b0001, 1'b1, 4'b0111, 1'b1, 1'b1},
    '{4'b0000, 4'b0001, 1'b1, 4'b1111, 1'b0, 1'b0}
  };

  initial begin
    a = '0; b = '0; c0 = MODE_ADD; in_valid = 1'b1;
    rst_n = 1'b0;
    exp_s = '0; exp_ovf = 1'b0; exp_cout = 1'b0; exp_v = 1'b0;

    // Inputs are active during reset and must be ignored.
    a = 4'b0111; b = 4'b0001;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    #3 rst_n = 1'b1;

    // Directed vectors, back-to-back, compared against hand-derived values.
    foreach (vecs[i]) begin
      a = vecs[i].a; b = vecs[i].b; c0 = vecs[i].c0; in_valid = 1'b1;
      @(posedge clk);
      #1;
      exp_s = vecs[i].s; exp_ovf = vecs[i].ovf; exp_cout = vecs[i].cout;
      exp_v = 1'b1;
      check_outputs($sformatf("vec%0d", i));
    end

    // Valid/hold: 1,0,1 with different operands on the idle cycle.
    cycle(4'b0101, 4'b0010, MODE_ADD, 1'b1, "hold_v1");
    cycle(4'b1111, 4'b1111, MODE_SUB, 1'b0, "hold_v0");
    cycle(4'b0110, 4'b0011, MODE_SUB, 1'b1, "hold_v1b");

    // Mid-stream reset, asserted between clock edges.
    cycle(4'b0111, 4'b0111, MODE_ADD, 1'b1, "pre_rst");
    a = 4'b0011; b = 4'b0100; c0 = MODE_ADD; in_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    exp_s = '0; exp_ovf = 1'b0; exp_cout = 1'b0; exp_v = 1'b0;
    check_outputs("rst_async");
    @(posedge clk);
    #1;
    check_outputs("rst_held");
    #2 rst_n = 1'b1;
    #1;
    check_outputs("rst_release");
    cycle(4'b0100, 4'b0101, MODE_SUB, 1'b1, "post_rst");

    // Randomized traffic: mode and valid change freely every cycle.
    for (int i = 0; i < 300; i++) begin
      cycle(W'($urandom), W'($urandom), 1'($urandom),
            ($urandom_range(0, 3) != 0), $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_add_sub
